// File: rtl/pc_fetch_sequencer.sv
// Program counter and instruction fetch sequencer between the PC stage and decode.
// Optional macro PC_ALIGN_CHECK_EN turns misaligned redirects into exceptions and drives o_align_err.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_1000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080,
  parameter logic [31:0] PC_STEP    = 32'd4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic        o_instr_valid,
  input  logic        i_instr_ready,
  output logic [31:0] o_instr,
  output logic [31:0] o_instr_pc,
  input  logic        i_redir_valid,
  input  logic [31:0] i_redir_addr,
  input  logic        i_exc_valid,
  output logic [31:0] o_pc,
  output logic        o_align_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_HOLD
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_req_addr;
  logic        r_imem_req;
  logic        r_kill;
  logic        r_instr_valid;
  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;

  logic        w_misaligned;
  logic        w_to_exc;
  logic        w_redirect;
  logic [31:0] w_target;
  logic [31:0] w_pc_seq;

`ifdef PC_ALIGN_CHECK_EN
  assign w_misaligned = i_redir_valid && (i_redir_addr[1:0] != 2'b00);
`else
  assign w_misaligned = 1'b0;
`endif

  // Exceptions (including bad redirects) beat ordinary redirects, which beat sequential flow.
  assign w_to_exc   = i_exc_valid | w_misaligned;
  assign w_redirect = w_to_exc | i_redir_valid;
  assign w_target   = w_to_exc ? EXC_VECTOR : i_redir_addr;
  assign w_pc_seq   = r_pc + PC_STEP;

  // r_req_addr holds the address of the outstanding request so a redirect during a
  // wait cannot disturb the address the memory is already servicing.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_req_addr    <= RESET_PC;
      r_imem_req    <= 1'b0;
      r_kill        <= 1'b0;
      r_instr_valid <= 1'b0;
      r_instr       <= 32'h0;
      r_instr_pc    <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state    <= S_REQ;
          r_imem_req <= 1'b1;
          if (w_redirect) begin
            r_pc       <= w_target;
            r_req_addr <= w_target;
          end else begin
            r_req_addr <= r_pc;
          end
        end
        S_REQ: begin
          if (i_imem_ack) begin
            r_kill <= 1'b0;
            if (w_redirect) begin
              r_pc       <= w_target;
              r_req_addr <= w_target;
            end else if (r_kill) begin
              r_req_addr <= r_pc;
            end else begin
              r_instr       <= i_imem_rdata;
              r_instr_pc    <= r_req_addr;
              r_instr_valid <= 1'b1;
              r_imem_req    <= 1'b0;
              r_state       <= S_HOLD;
            end
          end else if (w_redirect) begin
            r_pc   <= w_target;
            r_kill <= 1'b1;
          end
        end
        S_HOLD: begin
          if (w_redirect) begin
            r_pc          <= w_target;
            r_req_addr    <= w_target;
            r_instr_valid <= 1'b0;
            r_imem_req    <= 1'b1;
            r_state       <= S_REQ;
          end else if (i_instr_ready) begin
            r_pc          <= w_pc_seq;
            r_req_addr    <= w_pc_seq;
            r_instr_valid <= 1'b0;
            r_imem_req    <= 1'b1;
            r_state       <= S_REQ;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_imem_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  logic r_align_err;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_align_err <= 1'b0;
    end else begin
      r_align_err <= w_misaligned;
    end
  end

  assign o_align_err = r_align_err;
`else
  assign o_align_err = 1'b0;
`endif

  assign o_imem_req    = r_imem_req;
  assign o_imem_addr   = r_req_addr;
  assign o_instr_valid = r_instr_valid;
  assign o_instr       = r_instr;
  assign o_instr_pc    = r_instr_pc;
  assign o_pc          = r_pc;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Scoreboard bench for pc_fetch_sequencer: directed fetch/redirect/exception/reset scenarios.
// Honours PC_ALIGN_CHECK_EN for the misaligned-redirect scenario.
module tb_pc_fetch_sequencer;

  logic        clk;
  logic        rstN;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemRdata;
  logic        instrValid;
  logic        instrReady;
  logic [31:0] instr;
  logic [31:0] instrPc;
  logic        redirValid;
  logic [31:0] redirAddr;
  logic        excValid;
  logic [31:0] pc;
  logic        alignErr;

  typedef struct {
    logic [31:0] word;
    logic [31:0] addr;
  } instr_exp_t;

  logic [31:0] expAddrQ[$];
  instr_exp_t  expInstrQ[$];

  int assertCount = 0;
  int failCount   = 0;
  bit memEnable   = 1'b0;
  int memLatency  = 0;
  int waitCnt;

  pc_fetch_sequencer dut (
    .i_clk         (clk),
    .i_rst_n       (rstN),
    .o_imem_req    (imemReq),
    .o_imem_addr   (imemAddr),
    .i_imem_ack    (imemAck),
    .i_imem_rdata  (imemRdata),
    .o_instr_valid (instrValid),
    .i_instr_ready (instrReady),
    .o_instr       (instr),
    .o_instr_pc    (instrPc),
    .i_redir_valid (redirValid),
    .i_redir_addr  (redirAddr),
    .i_exc_valid   (excValid),
    .o_pc          (pc),
    .o_align_err   (alignErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: acks after memLatency wait cycles; the word is the address plus a fixed tag.
  assign imemAck   = memEnable && imemReq && (waitCnt >= memLatency);
  assign imemRdata = imemAddr + 32'h1111_0000;

  always @(posedge clk or negedge rstN) begin
    if (!rstN) waitCnt <= 0;
    else if (imemReq && !imemAck) waitCnt <= waitCnt + 1;
    else waitCnt <= 0;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit ready, input bit redir, input logic [31:0] raddr, input bit exc);
    instrReady = ready;
    redirValid = redir;
    redirAddr  = raddr;
    excValid   = exc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushFetch(input logic [31:0] addr);
    expAddrQ.push_back(addr);
  endtask

  task automatic pushInstr(input logic [31:0] word, input logic [31:0] addr);
    instr_exp_t e;
    e.word = word;
    e.addr = addr;
    expInstrQ.push_back(e);
  endtask

  task automatic doReset();
    rstN = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    memEnable  = 1'b0;
    memLatency = 0;
    tick();
    tick();
    checkOutput("reset pc", pc, 32'h0000_1000);
    checkOutput("reset imem_req", {31'h0, imemReq}, 32'h0);
    checkOutput("reset instr_valid", {31'h0, instrValid}, 32'h0);
    checkOutput("reset instr", instr, 32'h0);
    checkOutput("reset instr_pc", instrPc, 32'h0);
    checkOutput("reset align_err", {31'h0, alignErr}, 32'h0);
  endtask

  // Monitor: every memory handshake and every decode handshake is matched against the scoreboard.
  always @(negedge clk) begin
    instr_exp_t e;
    if (rstN) begin
      if (imemReq && imemAck) begin
        if (expAddrQ.size() == 0) begin
          assertCount++;
          failCount++;
          $display("[TB] FAIL unexpected fetch: got 0x%08h, expected no fetch", imemAddr);
        end else begin
          checkOutput("fetch addr", imemAddr, expAddrQ.pop_front());
        end
      end
      if (instrValid && instrReady) begin
        if (expInstrQ.size() == 0) begin
          assertCount++;
          failCount++;
          $display("[TB] FAIL unexpected instr: got pc 0x%08h word 0x%08h, expected none", instrPc, instr);
        end else begin
          e = expInstrQ.pop_front();
          checkOutput("instr word", instr, e.word);
          checkOutput("instr pc", instrPc, e.addr);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rstN = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);

    // T1: zero-wait sequential fetch.
    doReset();
    pushFetch(32'h0000_1000); pushInstr(32'h1111_1000, 32'h0000_1000);
    pushFetch(32'h0000_1004); pushInstr(32'h1111_1004, 32'h0000_1004);
    pushFetch(32'h0000_1008); pushInstr(32'h1111_1008, 32'h0000_1008);
    memEnable = 1'b1;
    rstN = 1'b1;
    checkOutput("T1 idle no req", {31'h0, imemReq}, 32'h0);
    tick();
    checkOutput("T1 first req", {31'h0, imemReq}, 32'h1);
    repeat (5) tick();
    memEnable = 1'b0;
    tick();
    checkOutput("T1 stall addr", imemAddr, 32'h0000_100C);
    checkOutput("T1 stall pc", pc, 32'h0000_100C);

    // T2: redirect while holding a word that decode has not taken.
    doReset();
    pushFetch(32'h0000_1000); pushInstr(32'h1111_1000, 32'h0000_1000);
    pushFetch(32'h0000_1004);
    pushFetch(32'h0000_2000); pushInstr(32'h1111_2000, 32'h0000_2000);
    memEnable = 1'b1;
    rstN = 1'b1;
    repeat (3) tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    checkOutput("T2 hold valid", {31'h0, instrValid}, 32'h1);
    checkOutput("T2 hold pc", instrPc, 32'h0000_1004);
    checkOutput("T2 hold word", instr, 32'h1111_1004);
    tick();
    checkOutput("T2 hold pc stable", instrPc, 32'h0000_1004);
    applyStimulus(1'b0, 1'b1, 32'h0000_2000, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("T2 word dropped", {31'h0, instrValid}, 32'h0);
    checkOutput("T2 redirect addr", imemAddr, 32'h0000_2000);
    tick();
    memEnable = 1'b0;
    tick();
    checkOutput("T2 next pc", pc, 32'h0000_2004);

    // T3: redirect during a delayed fetch kills the returning word.
    doReset();
    pushFetch(32'h0000_1000);
    pushFetch(32'h0000_3000); pushInstr(32'h1111_3000, 32'h0000_3000);
    memEnable  = 1'b1;
    memLatency = 3;
    rstN = 1'b1;
    tick();
    tick();
    applyStimulus(1'b1, 1'b1, 32'h0000_3000, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("T3 req held", {31'h0, imemReq}, 32'h1);
    checkOutput("T3 addr stable", imemAddr, 32'h0000_1000);
    checkOutput("T3 pc redirected", pc, 32'h0000_3000);
    tick();
    memLatency = 0;
    tick();
    checkOutput("T3 killed word", {31'h0, instrValid}, 32'h0);
    checkOutput("T3 refetch addr", imemAddr, 32'h0000_3000);
    tick();
    memEnable = 1'b0;
    tick();
    checkOutput("T3 next pc", pc, 32'h0000_3004);

    // T4: exception beats a simultaneous redirect.
    doReset();
    pushFetch(32'h0000_1000);
    pushFetch(32'h0000_0080); pushInstr(32'h1111_0080, 32'h0000_0080);
    rstN = 1'b1;
    tick();
    tick();
    applyStimulus(1'b1, 1'b1, 32'h0000_4000, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("T4 exc pc", pc, 32'h0000_0080);
    memEnable = 1'b1;
    tick();
    checkOutput("T4 vector fetch", imemAddr, 32'h0000_0080);
    tick();
    memEnable = 1'b0;
    tick();
    checkOutput("T4 next pc", pc, 32'h0000_0084);

    // T5: redirect coincident with ack, then wrap past the top of the address space.
    doReset();
    pushFetch(32'h0000_1000);
    pushFetch(32'hFFFF_FFFC); pushInstr(32'h1110_FFFC, 32'hFFFF_FFFC);
    pushFetch(32'h0000_0000); pushInstr(32'h1111_0000, 32'h0000_0000);
    memEnable = 1'b1;
    rstN = 1'b1;
    tick();
    applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("T5 ack word dropped", {31'h0, instrValid}, 32'h0);
    checkOutput("T5 top addr", imemAddr, 32'hFFFF_FFFC);
    tick();
    tick();
    checkOutput("T5 wrap addr", imemAddr, 32'h0000_0000);
    tick();
    memEnable = 1'b0;
    tick();
    checkOutput("T5 next pc", pc, 32'h0000_0004);

    // T6: asynchronous reset while a request is outstanding.
    doReset();
    rstN = 1'b1;
    tick();
    tick();
    checkOutput("T6 req before reset", {31'h0, imemReq}, 32'h1);
    rstN = 1'b0;
    #1;
    checkOutput("T6 req dropped", {31'h0, imemReq}, 32'h0);
    checkOutput("T6 pc reset", pc, 32'h0000_1000);
    checkOutput("T6 valid reset", {31'h0, instrValid}, 32'h0);
    tick();
    rstN = 1'b1;

    // Misaligned redirect while waiting for an ack that never comes.
    tick();
    tick();
    applyStimulus(1'b1, 1'b1, 32'h0000_2002, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
`ifdef PC_ALIGN_CHECK_EN
    checkOutput("align pc", pc, 32'h0000_0080);
    checkOutput("align err pulse", {31'h0, alignErr}, 32'h1);
`else
    checkOutput("align pc", pc, 32'h0000_2002);
    checkOutput("align err tied", {31'h0, alignErr}, 32'h0);
`endif
    tick();
    checkOutput("align err clears", {31'h0, alignErr}, 32'h0);

    repeat (3) tick();
    checkOutput("fetch queue drained", expAddrQ.size(), 32'd0);
    checkOutput("instr queue drained", expInstrQ.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
